// File: rtl/mm_out_drain.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mm_out_drain                                                    |
// | Desc   : Ping-pong capture of finished matmul tiles, streamed out one    |
// |          tagged row per cycle over valid/ready.                          |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module mm_out_drain #(
  parameter  int LANES    = 16,
  parameter  int AW       = 24,
  parameter  int DEPTH    = 16,
  parameter  int TR       = 32,
  parameter  int TC       = 32,
  localparam int c_ROW_W  = LANES * AW,
  localparam int c_ADDR_W = $clog2(DEPTH),
  localparam int c_TRW    = $clog2(TR),
  localparam int c_TCW    = $clog2(TC)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_we,
  input  logic [c_ADDR_W-1:0] i_addr,
  input  logic [c_ROW_W-1:0]  i_data,
  input  logic                i_tile_done,
  output logic                o_full,
  output logic                o_ovf,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [c_ROW_W-1:0]  o_data,
  output logic [c_ADDR_W-1:0] o_row_idx,
  output logic [c_TRW-1:0]    o_tile_row,
  output logic [c_TCW-1:0]    o_tile_col,
  output logic                o_last,
  output logic                o_mtrx_last
);

  localparam logic [c_ADDR_W-1:0] c_LAST_ROW = c_ADDR_W'(DEPTH - 1);
  localparam logic [c_TRW-1:0]    c_TR_LAST  = c_TRW'(TR - 1);
  localparam logic [c_TCW-1:0]    c_TC_LAST  = c_TCW'(TC - 1);

  logic [c_ROW_W-1:0]  r_mem [2][DEPTH];
  logic [1:0]          r_full;
  logic [c_TRW-1:0]    r_tag_row [2];
  logic [c_TCW-1:0]    r_tag_col [2];
  logic                r_wbank;
  logic                r_rbank;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_TRW-1:0]    r_tile_row;
  logic [c_TCW-1:0]    r_tile_col;
  logic                r_ovf;

  logic w_full;
  logic w_close;
  logic w_drop;
  logic w_wr_en;
  logic w_load;
  logic w_rd_last;
  logic w_mtrx_tag;

  assign w_full     = &r_full;
  assign w_close    = i_tile_done && !r_full[r_wbank];
  assign w_drop     = i_tile_done && w_full;
  assign w_wr_en    = i_we && !w_full;
  assign w_load     = (!o_valid || i_ready) && r_full[r_rbank];
  assign w_rd_last  = w_load && (r_rd_ptr == c_LAST_ROW);
  assign w_mtrx_tag = (r_tag_row[r_rbank] == c_TR_LAST) && (r_tag_col[r_rbank] == c_TC_LAST);

  assign o_full = w_full;
  assign o_ovf  = r_ovf;

  // Row storage is deliberately not reset; the full flags gate every read.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wbank][i_addr] <= i_data;
    end
  end

  // A bank can never be closed and released in the same cycle: closing needs it
  // empty, releasing needs it full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        r_full[b]    <= 1'b0;
        r_tag_row[b] <= '0;
        r_tag_col[b] <= '0;
      end
    end else if (i_clr) begin
      r_full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_close && (r_wbank == 1'(b))) begin
          r_full[b]    <= 1'b1;
          r_tag_row[b] <= r_tile_row;
          r_tag_col[b] <= r_tile_col;
        end else if (w_rd_last && (r_rbank == 1'(b))) begin
          r_full[b] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wbank    <= 1'b0;
      r_tile_row <= '0;
      r_tile_col <= '0;
      r_ovf      <= 1'b0;
    end else if (i_clr) begin
      r_wbank    <= 1'b0;
      r_tile_row <= '0;
      r_tile_col <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_close) begin
        r_wbank <= !r_wbank;
        if (r_tile_col == c_TC_LAST) begin
          r_tile_col <= '0;
          r_tile_row <= (r_tile_row == c_TR_LAST) ? '0 : r_tile_row + c_TRW'(1);
        end else begin
          r_tile_col <= r_tile_col + c_TCW'(1);
        end
      end
    end
  end

  // Single registered output stage; held whenever the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rbank     <= 1'b0;
      r_rd_ptr    <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_row_idx   <= '0;
      o_tile_row  <= '0;
      o_tile_col  <= '0;
      o_last      <= 1'b0;
      o_mtrx_last <= 1'b0;
    end else if (i_clr) begin
      r_rbank     <= 1'b0;
      r_rd_ptr    <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_mtrx_last <= 1'b0;
    end else if (w_load) begin
      o_valid     <= 1'b1;
      o_data      <= r_mem[r_rbank][r_rd_ptr];
      o_row_idx   <= r_rd_ptr;
      o_tile_row  <= r_tag_row[r_rbank];
      o_tile_col  <= r_tag_col[r_rbank];
      o_last      <= w_rd_last;
      o_mtrx_last <= w_rd_last && w_mtrx_tag;
      if (w_rd_last) begin
        r_rd_ptr <= '0;
        r_rbank  <= !r_rbank;
      end else begin
        r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      end
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
